// File: rtl/pipe_scoreboard_if.sv
// Decode-side hazard interface: decode instruction fields and branch flush in,
// stall, forwarding selects, stall counter and busy flag out.
interface pipe_scoreboard_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3
) ();
  logic             id_valid;
  logic [AW-1:0]    id_rs1;
  logic [AW-1:0]    id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [AW-1:0]    id_rd;
  logic             id_is_wb;
  logic             id_is_load;
  logic             br_en;
  logic             stall;
  logic [DEPTH-1:0] fwd_sel1;
  logic [DEPTH-1:0] fwd_sel2;
  logic [31:0]      stall_cnt;
  logic             busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_is_wb, id_is_load, br_en,
    input  stall, fwd_sel1, fwd_sel2, stall_cnt, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_is_wb, id_is_load, br_en,
    output stall, fwd_sel1, fwd_sel2, stall_cnt, busy
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Read-after-write hazard scoreboard: tracks writers in the stages after decode,
// stalls decode on unresolvable hazards and selects forwarding sources.
module pipe_scoreboard #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int FWD      = 1,
  parameter int LD_AVAIL = 1
) (
  input  logic              clock,
  input  logic              reset,
  pipe_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic          valid;
    logic          wb;
    logic          load;
    logic [AW-1:0] rd;
  } slot_t;

  typedef struct packed {
    logic             stall;
    logic [DEPTH-1:0] sel;
  } src_res_t;

  slot_t [DEPTH-1:0] slots;
  logic  [31:0]      cnt;
  src_res_t          res1;
  src_res_t          res2;
  slot_t             new_slot;
  logic              active;
  logic              stall_int;
  logic              busy_int;

  // Only the youngest matching writer (lowest slot) decides the outcome.
  function automatic src_res_t resolve(input logic used, input logic [AW-1:0] src,
                                       input slot_t [DEPTH-1:0] s);
    src_res_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && used && (src != '0) && s[i].valid && s[i].wb && (s[i].rd == src)) begin
        found = 1'b1;
        if (FWD == 0) begin
          if (i < DEPTH-1) r.stall = 1'b1;
        end else if (s[i].load && (i < LD_AVAIL)) begin
          r.stall = 1'b1;
        end else if (i < DEPTH-1) begin
          r.sel[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res1      = resolve(bus.id_rs1_used, bus.id_rs1, slots);
    res2      = resolve(bus.id_rs2_used, bus.id_rs2, slots);
    active    = reset && bus.id_valid && !bus.br_en;
    stall_int = active && (res1.stall || res2.stall);
    new_slot  = '0;
    if (active && !stall_int) begin
      new_slot.valid = 1'b1;
      new_slot.wb    = bus.id_is_wb && (bus.id_rd != '0);
      new_slot.load  = bus.id_is_load;
      new_slot.rd    = bus.id_rd;
    end
    busy_int = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_int = busy_int | slots[i].valid;
  end

  assign bus.stall     = stall_int;
  assign bus.fwd_sel1  = (active && !stall_int) ? res1.sel : '0;
  assign bus.fwd_sel2  = (active && !stall_int) ? res2.sel : '0;
  assign bus.stall_cnt = cnt;
  assign bus.busy      = busy_int;

  // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the slot array is a handful of flops and its valid bits drive busy, so it is cleared.
      slots <= '0;
      cnt   <= '0;
    end else begin
      for (int i = DEPTH-1; i > 0; i--) slots[i] <= slots[i-1];
      slots[0] <= new_slot;
      if (stall_int && (cnt != 32'hFFFF_FFFF)) cnt <= cnt + 32'd1;
    end
  end

endmodule
